sgmii_rate_ctrl: RTL
====================

# sgmii_rate_ctrl

Sequencer that turns the resolved SGMII/GbE operational rate into a safe, glitch-free datapath rate switch. Sits between rate resolution and the 8-bit GMII/MII rate-adaptation datapath: it qualifies rate changes, drains in-flight frames, commits the new rate, and generates the 125 MHz clock-enable strobe (every cycle, 1 in 10, or 1 in 100). It is the only block allowed to change the rate the datapath sees.

## Interface
- STABLE_CYCLES, 16: consecutive cycles a candidate rate must stay constant before it is accepted (range 1..255).
- DRAIN_TIMEOUT, 4096: maximum DRAIN cycles before a forced apply (range 2..65535).

- clk  in  1  125 MHz core clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- operational_rate  in  2  resolved rate: 00=10M, 01=100M, 10=1G, 11=invalid.
- link_ok  in  1  link up / auto-negotiation complete.
- tx_busy  in  1  transmit path mid-frame.
- rx_busy  in  1  receive path mid-frame.
- active_rate  out  2  committed rate driving the datapath.
- ce  out  1  registered rate strobe.
- datapath_en  out  1  datapath enable (1 = frames may start).
- rate_change  out  1  one-cycle pulse on commit.
- drain_timeout  out  1  one-cycle pulse when DRAIN ends by timeout.

## Operation
- States: LINK_DOWN, QUAL_UP, QUAL_CHG, DRAIN, APPLY, RUN.
- Reset values: state=LINK_DOWN, active_rate=2'b10, ce=0, datapath_en=0, rate_change=0, drain_timeout=0, all counters 0.
- datapath_en is a decode of the state register: 1 iff the state is RUN or QUAL_CHG.
- LINK_DOWN:
  - If link_ok=1 and operational_rate≠11, latch it as candidate, clear stab_cnt, and go to QUAL_UP.
- QUAL_UP / QUAL_CHG:
  - If link_ok=0, go to LINK_DOWN.
  - If operational_rate≠candidate, reload candidate and clear stab_cnt.
  - If operational_rate=11, go to LINK_DOWN from QUAL_UP, or to RUN from QUAL_CHG.
  - Otherwise increment stab_cnt. The rate is qualified on the cycle stab_cnt reaches STABLE_CYCLES-1; the entry cycle counts as the first.
  - Qualified in QUAL_UP: go to RUN if candidate=active_rate, else to APPLY.
  - Qualified in QUAL_CHG: go to RUN if candidate=active_rate (glitch rejected), else to DRAIN.
- RUN:
  - If link_ok=0, go to LINK_DOWN.
  - Else if operational_rate≠active_rate and ≠11, latch candidate, clear stab_cnt, and go to QUAL_CHG.
  - Link loss has priority over a rate change.
- DRAIN:
  - drn_cnt counts from 0.
  - If link_ok=0, go to LINK_DOWN; no commit, active_rate is unchanged.
  - Else if tx_busy=0 and rx_busy=0, go to APPLY.
  - Else if drn_cnt=DRAIN_TIMEOUT-1, pulse drain_timeout and go to APPLY.
  - Idle wins over timeout on the same cycle.
- APPLY (exactly one cycle): active_rate←candidate, rate_change=1, divider cleared, then go to RUN.
- Divider:
  - N=1/10/100 for active_rate 10/01/00.
  - div_cnt wraps at N-1 and is cleared in APPLY.
  - ce is registered: ce ← (div_cnt==0), forced 0 during rst and during APPLY.
  - The divider runs in every state, including LINK_DOWN.
- active_rate never takes the value 11 and only changes in APPLY.

## Timing
- After rst falls (cycle 0), ce first rises at cycle 1. At 1G, ce stays high every cycle from then on.
- Link-up at the current rate: link_ok rises at cycle T, QUAL_UP spans T+1..T+STABLE_CYCLES, and datapath_en=1 from T+STABLE_CYCLES+1.
- Rate change with an idle datapath:
  - The change is seen in RUN at T; QUAL_CHG spans T+1..T+S, where S=STABLE_CYCLES.
  - DRAIN begins at T+S+1 and datapath_en falls there.
  - APPLY is at T+S+2, with rate_change and the active_rate update.
  - RUN begins at T+S+3 and datapath_en rises there.
  - ce=0 at T+S+3; the first strobe at the new rate is at T+S+4, then every N cycles.
- Worst-case DRAIN duration is DRAIN_TIMEOUT cycles.
- rst asserted in any state returns all outputs to their reset values on the next edge; an in-progress change is discarded.

## Test plan
- Reset, then link_ok=1 with operational_rate=10 held: datapath_en rises 17 cycles after link_ok (defaults), ce constant 1, no rate_change.
- From RUN at 1G, set rate=01 while tx_busy=1 for 50 cycles:
  - datapath_en stays 1 for 16 cycles, then 0.
  - APPLY comes one cycle after tx_busy falls: rate_change pulse, active_rate=01.
  - ce then pulses every 10 cycles.
- From RUN, glitch operational_rate to 00 for 5 cycles, then back to 10: the block goes QUAL_CHG and then RUN, datapath_en never drops, and active_rate stays 10.
- In DRAIN, hold tx_busy=1 permanently: drain_timeout pulses after 4096 DRAIN cycles, followed by APPLY.
- Drop link_ok in DRAIN: the block goes to LINK_DOWN with active_rate unchanged and no rate_change.
- Drive operational_rate=11 in LINK_DOWN with link_ok=1: the block stays in LINK_DOWN. Assert rst mid-QUAL_CHG: all outputs return to their reset values, with active_rate=10.

Source files
------------

// File: rtl/sgmii_rate_ctrl.sv
// Qualifies resolved SGMII rate changes, drains in-flight frames, commits the
// new rate to the datapath and generates the matching 125 MHz clock-enable.
module sgmii_rate_ctrl #(
    parameter int STABLE_CYCLES = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] operational_rate,
    input  logic       link_ok,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic [1:0] active_rate,
    output logic       ce,
    output logic       datapath_en,
    output logic       rate_change,
    output logic       drain_timeout
);

    typedef enum logic [2:0] {
        LINK_DOWN,
        QUAL_UP,
        QUAL_CHG,
        DRAIN,
        APPLY,
        RUN
    } state_t;

    localparam logic [1:0]  RATE_1G      = 2'b10;
    localparam logic [1:0]  RATE_100M    = 2'b01;
    localparam logic [1:0]  RATE_INVALID = 2'b11;
    localparam logic [7:0]  STAB_LAST    = 8'(STABLE_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST   = 16'(DRAIN_TIMEOUT - 1);

    state_t      state;
    logic [1:0]  candidate;
    logic [7:0]  stab_cnt;
    logic [15:0] drn_cnt;
    logic [6:0]  div_cnt;
    logic [6:0]  div_last;

    always_comb begin
        div_last = 7'd99;
        case (active_rate)
            RATE_1G:   div_last = 7'd0;
            RATE_100M: div_last = 7'd9;
            default:   div_last = 7'd99;
        endcase
    end

    assign datapath_en = (state == RUN) || (state == QUAL_CHG);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LINK_DOWN;
            candidate     <= RATE_1G;
            stab_cnt      <= '0;
            drn_cnt       <= '0;
            div_cnt       <= '0;
            active_rate   <= RATE_1G;
            ce            <= 1'b0;
            rate_change   <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            rate_change   <= 1'b0;
            drain_timeout <= 1'b0;

            // The divider free-runs in every state; APPLY restarts it at the new rate.
            if (state == APPLY) begin
                div_cnt <= '0;
                ce      <= 1'b0;
            end else begin
                ce      <= (div_cnt == 7'd0);
                div_cnt <= (div_cnt >= div_last) ? 7'd0 : div_cnt + 7'd1;
            end

            case (state)
                LINK_DOWN: begin
                    if (link_ok && operational_rate != RATE_INVALID) begin
                        candidate <= operational_rate;
                        stab_cnt  <= '0;
                        state     <= QUAL_UP;
                    end
                end

                QUAL_UP, QUAL_CHG: begin
                    if (!link_ok) begin
                        state <= LINK_DOWN;
                    end else if (operational_rate == RATE_INVALID) begin
                        state <= (state == QUAL_UP) ? LINK_DOWN : RUN;
                    end else if (operational_rate != candidate) begin
                        candidate <= operational_rate;
                        stab_cnt  <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        // A qualified rate equal to the committed one needs no switch.
                        if (candidate == active_rate) begin
                            state <= RUN;
                        end else if (state == QUAL_UP) begin
                            state <= APPLY;
                        end else begin
                            drn_cnt <= '0;
                            state   <= DRAIN;
                        end
                    end else begin
                        stab_cnt <= stab_cnt + 8'd1;
                    end
                end

                DRAIN: begin
                    if (!link_ok) begin
                        state <= LINK_DOWN;
                    end else if (!tx_busy && !rx_busy) begin
                        state <= APPLY;
                    end else if (drn_cnt == DRAIN_LAST) begin
                        drain_timeout <= 1'b1;
                        state         <= APPLY;
                    end else begin
                        drn_cnt <= drn_cnt + 16'd1;
                    end
                end

                APPLY: begin
                    active_rate <= candidate;
                    rate_change <= 1'b1;
                    state       <= RUN;
                end

                RUN: begin
                    if (!link_ok) begin
                        state <= LINK_DOWN;
                    end else if (operational_rate != active_rate &&
                                 operational_rate != RATE_INVALID) begin
                        candidate <= operational_rate;
                        stab_cnt  <= '0;
                        state     <= QUAL_CHG;
                    end
                end

                default: state <= LINK_DOWN;
            endcase
        end
    end

endmodule
